// File: rtl/vga_game_scanner_pkg.sv
// -----------------------------------------------------------------------------
// vga_game_scanner_pkg
// Shared constants and helpers for the VGA game scanner.
//   - Default 640x480@60 raster timing (pixel clocks / lines).
//   - cnt_width(): counter width for a modulus n, never narrower than 1 bit.
//   - raster_flags_t: per-clock flags that travel down the alignment delay line.
// -----------------------------------------------------------------------------
package vga_game_scanner_pkg;

  // Horizontal timing, in pixel clocks
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Vertical timing, in lines
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Width of a counter that must hold 0..n-1; a 1-bit floor keeps degenerate
  // moduli (SCALE=1, GAME_W=1) from producing zero-width vectors.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flags produced at the game-side register stage and re-timed to the pins.
  typedef struct packed {
    logic win;
    logic hs_act;
    logic vs_act;
  } raster_flags_t;

endpackage

// File: rtl/vga_game_scanner_delay_line.sv
// -----------------------------------------------------------------------------
// vga_game_scanner_delay_line
// Fixed-depth shift register with asynchronous reset to a parameterised value.
// DEPTH=0 degenerates to a wire.
//   clk_i  in   pixel clock
//   rst_i  in   asynchronous active-high reset
//   d_i    in   WIDTH-bit data in
//   q_o    out  d_i delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module vga_game_scanner_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
        end else begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_game_scanner.sv
// -----------------------------------------------------------------------------
// vga_game_scanner
// Producer side of the game pixel stream. Runs the VGA raster, maps a centred
// GAME_W x GAME_H window (each game pixel SCALE x SCALE physical pixels) onto
// game coordinates, and turns the game's colour back into blanked VGA pixels
// with matching sync.
// Ports
//   vga_pix_clk_i        in   pixel clock (only clock)
//   rst_i                in   asynchronous active-high reset
//   game_r/g/b_i         in   game colour, valid GAME_LATENCY clks after sx/sy
//   sx_o, sy_o           out  game column / row (0 outside the window)
//   game_pix_stb_o       out  first clk of each game pixel (first line only)
//   frame_stb_o          out  one clk at game pixel (0,0)
//   display_enabled_o    out  beam inside the game window
//   hsync_o, vsync_o     out  VGA sync, aligned with vga_r/g/b_o
//   vga_r/g/b_o          out  registered colour, 0 outside the window
// Pipeline: counters -> game-side register -> GAME_LATENCY delay line ->
// output register. The delay line is fed from the game-side register so that
// the window flag meets exactly the colour the game returns for that sx/sy.
// -----------------------------------------------------------------------------
module vga_game_scanner
  import vga_game_scanner_pkg::*;
#(
  parameter int H_VISIBLE    = H_VISIBLE_DEF,
  parameter int H_FRONT      = H_FRONT_DEF,
  parameter int H_SYNC       = H_SYNC_DEF,
  parameter int H_BACK       = H_BACK_DEF,
  parameter int V_VISIBLE    = V_VISIBLE_DEF,
  parameter int V_FRONT      = V_FRONT_DEF,
  parameter int V_SYNC       = V_SYNC_DEF,
  parameter int V_BACK       = V_BACK_DEF,
  parameter bit SYNC_NEG     = 1'b1,
  parameter int GAME_W       = 224,
  parameter int GAME_H       = 288,
  parameter int SCALE        = 1,
  parameter int H_OFFSET     = 208,
  parameter int V_OFFSET     = 96,
  parameter int GAME_LATENCY = 2,
  localparam int SX_W        = cnt_width(GAME_W),
  localparam int SY_W        = cnt_width(GAME_H)
) (
  input  logic            vga_pix_clk_i,
  input  logic            rst_i,
  input  logic [3:0]      game_r_i,
  input  logic [3:0]      game_g_i,
  input  logic [3:0]      game_b_i,
  output logic [SX_W-1:0] sx_o,
  output logic [SY_W-1:0] sy_o,
  output logic            game_pix_stb_o,
  output logic            frame_stb_o,
  output logic            display_enabled_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic [3:0]      vga_r_o,
  output logic [3:0]      vga_g_o,
  output logic [3:0]      vga_b_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // +1 so that end-of-range bounds equal to the total still fit
  localparam int HC_W    = cnt_width(H_TOTAL + 1);
  localparam int VC_W    = cnt_width(V_TOTAL + 1);
  localparam int SUB_W   = cnt_width(SCALE);

  localparam logic [HC_W-1:0]  H_LAST_C   = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_LAST_C   = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0]  H_WIN_LO_C = HC_W'(H_OFFSET);
  localparam logic [HC_W-1:0]  H_WIN_HI_C = HC_W'(H_OFFSET + GAME_W * SCALE);
  localparam logic [VC_W-1:0]  V_WIN_LO_C = VC_W'(V_OFFSET);
  localparam logic [VC_W-1:0]  V_WIN_HI_C = VC_W'(V_OFFSET + GAME_H * SCALE);
  localparam logic [HC_W-1:0]  HS_LO_C    = HC_W'(H_VISIBLE + H_FRONT);
  localparam logic [HC_W-1:0]  HS_HI_C    = HC_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0]  VS_LO_C    = VC_W'(V_VISIBLE + V_FRONT);
  localparam logic [VC_W-1:0]  VS_HI_C    = VC_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SUB_W-1:0] SUB_LAST_C = SUB_W'(SCALE - 1);
  localparam logic [SX_W-1:0]  GX_LAST_C  = SX_W'(GAME_W - 1);
  localparam logic [SY_W-1:0]  GY_LAST_C  = SY_W'(GAME_H - 1);

  generate
    if (SCALE < 1 || GAME_LATENCY < 0 || H_OFFSET < 0 || V_OFFSET < 0 ||
        H_OFFSET + GAME_W * SCALE > H_VISIBLE ||
        V_OFFSET + GAME_H * SCALE > V_VISIBLE) begin : g_bad_window
      $error("vga_game_scanner: game window does not fit inside the visible area");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Raster and game-coordinate counters
  // ---------------------------------------------------------------------------
  logic [HC_W-1:0]  h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]  v_cnt_q, v_cnt_d;
  logic [SUB_W-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [SX_W-1:0]  gx_q, gx_d;
  logic [SY_W-1:0]  gy_q, gy_d;

  logic h_last, v_last, win_h, win_v, win, h_sub_wrap, v_sub_wrap;
  logic hs_act, vs_act;

  always_comb begin
    h_last     = (h_cnt_q == H_LAST_C);
    v_last     = (v_cnt_q == V_LAST_C);
    win_h      = (h_cnt_q >= H_WIN_LO_C) && (h_cnt_q < H_WIN_HI_C);
    win_v      = (v_cnt_q >= V_WIN_LO_C) && (v_cnt_q < V_WIN_HI_C);
    win        = win_h && win_v;
    h_sub_wrap = (hsub_q == SUB_LAST_C);
    v_sub_wrap = (vsub_q == SUB_LAST_C);
    hs_act     = (h_cnt_q >= HS_LO_C) && (h_cnt_q < HS_HI_C);
    vs_act     = (v_cnt_q >= VS_LO_C) && (v_cnt_q < VS_HI_C);

    h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;

    // Sub-counters and game coords sit at 0 everywhere outside the window,
    // so they are already cleared when the beam reaches the window start.
    hsub_d = '0;
    gx_d   = '0;
    if (win_h) begin
      if (!h_sub_wrap) begin
        hsub_d = hsub_q + 1'b1;
        gx_d   = gx_q;
      end else if (gx_q != GX_LAST_C) begin
        gx_d   = gx_q + 1'b1;
      end
    end

    // Vertical sub-counter and row advance only at the end of a line.
    vsub_d = vsub_q;
    gy_d   = gy_q;
    if (h_last) begin
      vsub_d = '0;
      gy_d   = '0;
      if (win_v) begin
        if (!v_sub_wrap) begin
          vsub_d = vsub_q + 1'b1;
          gy_d   = gy_q;
        end else if (gy_q != GY_LAST_C) begin
          gy_d   = gy_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge vga_pix_clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hsub_q  <= '0;
      vsub_q  <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hsub_q  <= hsub_d;
      vsub_q  <= vsub_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Game-side register stage (one clk after the counters)
  // ---------------------------------------------------------------------------
  logic [SX_W-1:0] sx_q;
  logic [SY_W-1:0] sy_q;
  logic            pix_stb_q, frame_stb_q, de_q, hs_act_q, vs_act_q;
  logic            first_sub;

  assign first_sub = (hsub_q == '0) && (vsub_q == '0);

  always_ff @(posedge vga_pix_clk_i or posedge rst_i) begin
    if (rst_i) begin
      sx_q        <= '0;
      sy_q        <= '0;
      pix_stb_q   <= 1'b0;
      frame_stb_q <= 1'b0;
      de_q        <= 1'b0;
      hs_act_q    <= 1'b0;
      vs_act_q    <= 1'b0;
    end else begin
      sx_q        <= win ? gx_q : '0;
      sy_q        <= win ? gy_q : '0;
      pix_stb_q   <= win && first_sub;
      frame_stb_q <= win && first_sub && (gx_q == '0) && (gy_q == '0);
      de_q        <= win;
      hs_act_q    <= hs_act;
      vs_act_q    <= vs_act;
    end
  end

  assign sx_o              = sx_q;
  assign sy_o              = sy_q;
  assign game_pix_stb_o    = pix_stb_q;
  assign frame_stb_o       = frame_stb_q;
  assign display_enabled_o = de_q;

  // ---------------------------------------------------------------------------
  // Re-time window and sync to the game's colour latency, then register pins
  // ---------------------------------------------------------------------------
  raster_flags_t flags_in, flags_dly;

  assign flags_in = '{win: de_q, hs_act: hs_act_q, vs_act: vs_act_q};

  vga_game_scanner_delay_line #(
    .WIDTH   ($bits(raster_flags_t)),
    .DEPTH   (GAME_LATENCY),
    .RST_VAL ('0)
  ) u_align (
    .clk_i (vga_pix_clk_i),
    .rst_i (rst_i),
    .d_i   (flags_in),
    .q_o   (flags_dly)
  );

  logic [3:0] vga_r_q, vga_g_q, vga_b_q;
  logic       hsync_q, vsync_q;

  always_ff @(posedge vga_pix_clk_i or posedge rst_i) begin
    if (rst_i) begin
      vga_r_q <= '0;
      vga_g_q <= '0;
      vga_b_q <= '0;
      hsync_q <= SYNC_NEG;  // inactive level
      vsync_q <= SYNC_NEG;
    end else begin
      vga_r_q <= flags_dly.win ? game_r_i : 4'h0;
      vga_g_q <= flags_dly.win ? game_g_i : 4'h0;
      vga_b_q <= flags_dly.win ? game_b_i : 4'h0;
      hsync_q <= flags_dly.hs_act ^ SYNC_NEG;
      vsync_q <= flags_dly.vs_act ^ SYNC_NEG;
    end
  end

  assign vga_r_o = vga_r_q;
  assign vga_g_o = vga_g_q;
  assign vga_b_o = vga_b_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;

endmodule

// File: tb/tb_vga_game_scanner.sv
// -----------------------------------------------------------------------------
// tb_vga_game_scanner
// Directed bench on a shrunken raster so whole frames fit in a short run:
//   H: 16 visible + 2 front + 3 sync + 3 back = 24 clks  (hsync low h=18..20)
//   V: 12 visible + 1 front + 2 sync + 2 back = 17 lines (vsync low v=13..14)
//   Game 4x3, SCALE=2, window h=4..11, v=3..8, GAME_LATENCY=2. Frame = 408 clks.
// k counts rising edges since reset release; raster position after edge k is
// p=k. Game-side outputs at k show position k-1, pins show position k-4.
// The game peer returns r = sx (F when outside the window), g = A, b = 5,
// two clocks after sx.
// -----------------------------------------------------------------------------
module tb_vga_game_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] game_r, game_g, game_b;
  logic [1:0] sx, sy;
  logic       pstb, fstb, de, hsync, vsync;
  logic [3:0] vga_r, vga_g, vga_b;

  // Game peer pipeline (two stages ahead of game_r)
  logic [3:0] gr1, gr2;

  int checks   = 0;
  int failures = 0;

  // Per-frame statistics over the second frame
  int n_pstb, n_fstb, n_de, n_hlow, n_vlow, n_gcol;

  always #5 clk = ~clk;

  vga_game_scanner #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_NEG(1'b1),
    .GAME_W(4), .GAME_H(3), .SCALE(2),
    .H_OFFSET(4), .V_OFFSET(3), .GAME_LATENCY(2)
  ) dut (
    .vga_pix_clk_i     (clk),
    .rst_i             (rst),
    .game_r_i          (game_r),
    .game_g_i          (game_g),
    .game_b_i          (game_b),
    .sx_o              (sx),
    .sy_o              (sy),
    .game_pix_stb_o    (pstb),
    .frame_stb_o       (fstb),
    .display_enabled_o (de),
    .hsync_o           (hsync),
    .vsync_o           (vsync),
    .vga_r_o           (vga_r),
    .vga_g_o           (vga_g),
    .vga_b_o           (vga_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge, then let the game peer react.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      gr1 = 4'h0; gr2 = 4'h0; game_r = 4'h0;
    end else begin
      game_r = gr2;
      gr2    = gr1;
      gr1    = de ? {2'b00, sx} : 4'hF;
    end
  endtask

  initial begin
    rst    = 1'b1;
    game_r = 4'h0;
    game_g = 4'hA;
    game_b = 4'h5;
    gr1    = 4'h0;
    gr2    = 4'h0;
    n_pstb = 0; n_fstb = 0; n_de = 0; n_hlow = 0; n_vlow = 0; n_gcol = 0;

    repeat (3) step();
    check_eq("rst_sx",    {30'd0, sx}, 32'd0);
    check_eq("rst_sy",    {30'd0, sy}, 32'd0);
    check_eq("rst_de",    {31'd0, de}, 32'd0);
    check_eq("rst_pstb",  {31'd0, pstb}, 32'd0);
    check_eq("rst_fstb",  {31'd0, fstb}, 32'd0);
    check_eq("rst_hsync", {31'd0, hsync}, 32'd1);
    check_eq("rst_vsync", {31'd0, vsync}, 32'd1);
    check_eq("rst_vga_g", {28'd0, vga_g}, 32'd0);
    rst = 1'b0;

    // ---- Phase 1: two frames plus part of a third ----
    for (int k = 1; k <= 898; k++) begin
      step();
      if (k >= 409 && k <= 816) begin
        n_pstb += int'(pstb);
        n_fstb += int'(fstb);
        n_de   += int'(de);
        n_hlow += int'(!hsync);
        n_vlow += int'(!vsync);
        n_gcol += int'(vga_g == 4'hA);
      end
      case (k)
        21:  check_eq("hs_pre",      {31'd0, hsync}, 32'd1);
        22:  check_eq("hs_first",    {31'd0, hsync}, 32'd0);
        24:  check_eq("hs_last",     {31'd0, hsync}, 32'd0);
        25:  check_eq("hs_post",     {31'd0, hsync}, 32'd1);
        76: begin
          check_eq("de_pre_win",   {31'd0, de}, 32'd0);
          check_eq("fstb_pre_win", {31'd0, fstb}, 32'd0);
        end
        77: begin
          check_eq("fstb_00",  {31'd0, fstb}, 32'd1);
          check_eq("pstb_00",  {31'd0, pstb}, 32'd1);
          check_eq("de_00",    {31'd0, de}, 32'd1);
          check_eq("sx_00",    {30'd0, sx}, 32'd0);
          check_eq("sy_00",    {30'd0, sy}, 32'd0);
        end
        78: begin
          check_eq("sx_hold",   {30'd0, sx}, 32'd0);
          check_eq("pstb_hsub", {31'd0, pstb}, 32'd0);
        end
        79: begin
          check_eq("sx_step",     {30'd0, sx}, 32'd1);
          check_eq("pstb_px1",    {31'd0, pstb}, 32'd1);
          check_eq("vga_r_blank", {28'd0, vga_r}, 32'd0);
          check_eq("vga_g_blank", {28'd0, vga_g}, 32'd0);
        end
        80: begin
          check_eq("vga_g_first", {28'd0, vga_g}, 32'hA);
          check_eq("vga_r_first", {28'd0, vga_r}, 32'd0);
        end
        82:  check_eq("vga_r_px1",   {28'd0, vga_r}, 32'd1);
        84: begin
          check_eq("sx_last",     {30'd0, sx}, 32'd3);
          check_eq("pstb_last",   {31'd0, pstb}, 32'd0);
        end
        85: begin
          check_eq("de_win_end",  {31'd0, de}, 32'd0);
          check_eq("sx_win_end",  {30'd0, sx}, 32'd0);
        end
        87: begin
          check_eq("vga_r_px3",   {28'd0, vga_r}, 32'd3);
          check_eq("vga_b_px3",   {28'd0, vga_b}, 32'd5);
        end
        88: begin
          check_eq("vga_r_post",  {28'd0, vga_r}, 32'd0);
          check_eq("vga_g_post",  {28'd0, vga_g}, 32'd0);
        end
        101: begin
          check_eq("sy_vsub1",    {30'd0, sy}, 32'd0);
          check_eq("pstb_vsub1",  {31'd0, pstb}, 32'd0);
          check_eq("de_vsub1",    {31'd0, de}, 32'd1);
        end
        127: begin
          check_eq("sy_row1",     {30'd0, sy}, 32'd1);
          check_eq("sx_row1",     {30'd0, sx}, 32'd1);
          check_eq("pstb_row1",   {31'd0, pstb}, 32'd1);
          check_eq("fstb_row1",   {31'd0, fstb}, 32'd0);
        end
        204: begin
          check_eq("sx_corner",   {30'd0, sx}, 32'd3);
          check_eq("sy_corner",   {30'd0, sy}, 32'd2);
        end
        221: check_eq("de_below",   {31'd0, de}, 32'd0);
        315: check_eq("vs_pre",     {31'd0, vsync}, 32'd1);
        316: check_eq("vs_first",   {31'd0, vsync}, 32'd0);
        363: check_eq("vs_last",    {31'd0, vsync}, 32'd0);
        364: check_eq("vs_post",    {31'd0, vsync}, 32'd1);
        485: begin
          check_eq("fstb_frame2", {31'd0, fstb}, 32'd1);
          check_eq("sx_frame2",   {30'd0, sx}, 32'd0);
        end
        816: begin
          check_eq("cnt_pstb",    n_pstb, 32'd12);
          check_eq("cnt_fstb",    n_fstb, 32'd1);
          check_eq("cnt_de",      n_de,   32'd48);
          check_eq("cnt_hs_low",  n_hlow, 32'd51);
          check_eq("cnt_vs_low",  n_vlow, 32'd48);
          check_eq("cnt_colour",  n_gcol, 32'd48);
        end
        898: begin
          check_eq("pre_rst_de",    {31'd0, de}, 32'd1);
          check_eq("pre_rst_sx",    {30'd0, sx}, 32'd2);
          check_eq("pre_rst_vga_g", {28'd0, vga_g}, 32'hA);
          check_eq("pre_rst_vga_r", {28'd0, vga_r}, 32'd1);
        end
        default: ;
      endcase
    end

    // ---- Mid-line reset: outputs must clear with no clock edge ----
    #2 rst = 1'b1;
    #1;
    check_eq("arst_de",    {31'd0, de}, 32'd0);
    check_eq("arst_sx",    {30'd0, sx}, 32'd0);
    check_eq("arst_vga_g", {28'd0, vga_g}, 32'd0);
    check_eq("arst_vga_r", {28'd0, vga_r}, 32'd0);
    check_eq("arst_hsync", {31'd0, hsync}, 32'd1);
    repeat (2) step();
    rst = 1'b0;

    // ---- Phase 2: raster restarts from (0,0) ----
    for (int k = 1; k <= 80; k++) begin
      step();
      case (k)
        21: check_eq("r2_hs_pre",   {31'd0, hsync}, 32'd1);
        22: check_eq("r2_hs_first", {31'd0, hsync}, 32'd0);
        76: check_eq("r2_fstb_pre", {31'd0, fstb}, 32'd0);
        77: begin
          check_eq("r2_fstb", {31'd0, fstb}, 32'd1);
          check_eq("r2_sy",   {30'd0, sy}, 32'd0);
        end
        79: check_eq("r2_sx_step", {30'd0, sx}, 32'd1);
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
